// File: rtl/loader_write_bridge_pkg.sv
// loader_write_bridge_pkg: shared widths, FSM encoding and FIFO entry type for the loader write bridge
package loader_write_bridge_pkg;
    localparam int ADDR_W_DEF = 22;
    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_LOG2_DEF = 2;
    typedef enum logic {IDLE, ISSUE} state_t;
    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } entry_t;
endpackage

// File: rtl/loader_write_bridge_if.sv
// loader_write_bridge_if: loader write input, SDRAM write request and status signals of the bridge
interface loader_write_bridge_if #(
    parameter int ADDR_W = 22,
    parameter int DATA_W = 8,
    parameter int DEPTH_LOG2 = 2
) ();
    logic slot;
    logic downloading;
    logic in_we;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_data;
    logic mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic pending;
    logic [DEPTH_LOG2:0] level;
    logic overflow;
    modport slave (
        input slot, downloading, in_we, in_addr, in_data,
        output mem_we, mem_addr, mem_data, pending, level, overflow
    );
    modport master (
        output slot, downloading, in_we, in_addr, in_data,
        input mem_we, mem_addr, mem_data, pending, level, overflow
    );
endinterface

// File: rtl/loader_write_bridge_fifo.sv
// loader_write_fifo: small synchronous FIFO with flush; a push in the flush cycle lands in the emptied buffer
module loader_write_fifo #(
    parameter int W = 30,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  push,
    input  logic                  pop,
    input  logic [W-1:0]          din,
    output logic [W-1:0]          dout,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    logic [W-1:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_q, rd_q;
    logic [DEPTH_LOG2:0] cnt_q;
    logic push_ok;
    assign full = cnt_q == (DEPTH_LOG2+1)'(DEPTH);
    assign empty = cnt_q == '0;
    assign level = cnt_q;
    assign dout = mem[rd_q];
    // a pop on a full buffer frees the slot the same-cycle push needs
    assign push_ok = push & (flush | ~full | pop);
    always_ff @(posedge clk) begin
        if (push_ok) mem[flush ? '0 : wr_q] <= din;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            wr_q <= DEPTH_LOG2'(push_ok);
            rd_q <= '0;
            cnt_q <= (DEPTH_LOG2+1)'(push_ok);
        end else begin
            wr_q <= wr_q + DEPTH_LOG2'(push_ok);
            rd_q <= rd_q + DEPTH_LOG2'(pop);
            cnt_q <= cnt_q + (DEPTH_LOG2+1)'(push_ok) - (DEPTH_LOG2+1)'(pop);
        end
    end
endmodule

// File: rtl/loader_write_bridge.sv
// loader_write_bridge: buffers loader byte writes and replays them to SDRAM, one per NES memory slot
module loader_write_bridge
    import loader_write_bridge_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input logic clk,
    input logic reset,
    loader_write_bridge_if.slave bus
);
    state_t state_q, state_d;
    logic [ADDR_W+DATA_W-1:0] head;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [DEPTH_LOG2:0] level;
    logic full, empty, pop, rise, dl_q, overflow_q;
    assign rise = bus.downloading & ~dl_q;
    // the flush cycle sees an empty buffer, so an issue in flight finishes its slot and then idles
    assign pop = bus.slot & ~empty & ~rise;
    loader_write_fifo #(.W(ADDR_W + DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
        .clk(clk),
        .reset(reset),
        .flush(rise),
        .push(bus.in_we),
        .pop(pop),
        .din({bus.in_addr, bus.in_data}),
        .dout(head),
        .full(full),
        .empty(empty),
        .level(level)
    );
    always_comb state_d = bus.slot ? (pop ? ISSUE : IDLE) : state_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            dl_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dl_q <= bus.downloading;
            if (pop) {addr_q, data_q} <= head;
            overflow_q <= ~rise & (overflow_q | (bus.in_we & full & ~pop));
        end
    end
    assign bus.mem_we = state_q == ISSUE;
    assign bus.mem_addr = addr_q;
    assign bus.mem_data = data_q;
    assign bus.level = level;
    assign bus.overflow = overflow_q;
    assign bus.pending = (level != '0) | bus.mem_we;
endmodule
